sample_delay_line: RTL and testbench

SAMPLE_DELAY_LINE -- requirements
Module: sample_delay_line

---
 rtl/sig_pkg.sv | 16 +
 rtl/ram2port.sv | 41 ++++
 rtl/sample_delay_line.sv | 141 ++++++++++++++
 tb/tb_sample_delay_line.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sig_pkg.sv
// Shared constants and types for the sample delay line.
//   DEF_ADDR_WIDTH : default buffer address width (depth = 2**DEF_ADDR_WIDTH)
//   DEF_DATA_WIDTH : default sample width
//   dly_state_t    : fill-state FSM encoding
package sig_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 9;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2
    } dly_state_t;

endpackage

// File: rtl/ram2port.sv
// Simple dual-port sample store: one synchronous write port, one synchronous
// read port. A same-address read and write in one cycle returns the old word.
// Contents are never reset.
//   clk       : clock
//   we_i      : write enable
//   waddr_i   : write address
//   wdata_i   : write data
//   re_i      : read enable (read data holds when low)
//   raddr_i   : read address
//   rdata_o   : registered read data
module ram2port #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Non-blocking write means a colliding read sees the previous word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sample_delay_line.sv
// Circular sample delay line. Each en cycle writes din and reads the sample
// written `offset` strobes earlier; outputs appear one cycle later. A small
// FSM tracks whether enough history exists, masking stale RAM words.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : sample strobe
//   clr         : synchronous flush of fill state (overrides en)
//   offset      : delay in samples
//   din         : incoming sample
//   dout_orig   : last written sample
//   dout_dly    : delayed sample (0 while not primed at read time)
//   dout_valid  : one-cycle pulse after each en cycle
//   primed      : delay line holds real history
module sample_delay_line
    import sig_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] offset,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout_orig,
    output logic [DATA_WIDTH-1:0] dout_dly,
    output logic                  dout_valid,
    output logic                  primed
);

    localparam logic [ADDR_WIDTH-1:0] FILL_MAX = '1;

    dly_state_t            state_q,     state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_WIDTH-1:0] fill_cnt_q,  fill_cnt_d;
    logic [DATA_WIDTH-1:0] orig_q,      orig_d;
    logic [DATA_WIDTH-1:0] byp_q,       byp_d;
    logic                  valid_q,     valid_d;
    logic                  primed_q,    primed_d;
    logic                  sel_byp_q,   sel_byp_d;
    logic                  mask_q,      mask_d;

    logic                  wr_en;
    logic                  hist_ok;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign wr_en   = en & ~clr;
    assign hist_ok = (fill_cnt_q >= offset);
    assign rd_addr = wr_ptr_q - offset;

    ram2port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .re_i    (wr_en),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        orig_d     = orig_q;
        byp_d      = byp_q;
        valid_d    = 1'b0;
        sel_byp_d  = sel_byp_q;
        mask_d     = mask_q;

        unique case (state_q)
            EMPTY:   if (wr_en) state_d = hist_ok ? RUN : FILL;
            FILL:    if (wr_en && hist_ok) state_d = RUN;
            RUN:     if (!hist_ok) state_d = FILL;
            default: state_d = EMPTY;
        endcase

        if (wr_en) begin
            wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
            if (fill_cnt_q != FILL_MAX) begin
                fill_cnt_d = fill_cnt_q + ADDR_WIDTH'(1);
            end
            orig_d    = din;
            byp_d     = din;
            valid_d   = 1'b1;
            // The read is real history only if this cycle lands in RUN.
            mask_d    = (state_d != RUN);
            // offset 0 collides with the write; the RAM would return old data.
            sel_byp_d = (offset == '0);
        end

        if (clr) begin
            state_d    = EMPTY;
            wr_ptr_d   = '0;
            fill_cnt_d = '0;
            orig_d     = '0;
            mask_d     = 1'b1;
            sel_byp_d  = 1'b0;
        end

        primed_d = (state_d == RUN);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            orig_q     <= '0;
            byp_q      <= '0;
            valid_q    <= 1'b0;
            primed_q   <= 1'b0;
            sel_byp_q  <= 1'b0;
            mask_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
            orig_q     <= orig_d;
            byp_q      <= byp_d;
            valid_q    <= valid_d;
            primed_q   <= primed_d;
            sel_byp_q  <= sel_byp_d;
            mask_q     <= mask_d;
        end
    end

    // Delayed output: registered RAM word or bypass word, selected by
    // registered flags; forced to 0 when the read had no real history.
    assign dout_dly   = mask_q ? '0 : (sel_byp_q ? byp_q : ram_rdata);
    assign dout_orig  = orig_q;
    assign dout_valid = valid_q;
    assign primed     = primed_q;

endmodule

// File: tb/tb_sample_delay_line.sv
// Directed self-checking bench for sample_delay_line (default widths).
module tb_sample_delay_line;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic [8:0] offset;
    logic [7:0] din;
    logic [7:0] dout_orig;
    logic [7:0] dout_dly;
    logic       dout_valid;
    logic       primed;

    int vecs = 0;
    int errs = 0;

    sample_delay_line dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clr        (clr),
        .offset     (offset),
        .din        (din),
        .dout_orig  (dout_orig),
        .dout_dly   (dout_dly),
        .dout_valid (dout_valid),
        .primed     (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs; return 1 time unit after the rising edge.
    task automatic step(input logic e, input logic c, input logic [8:0] o, input logic [7:0] d);
        en = e; clr = c; offset = o; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; offset = '0; din = '0;
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; offset = '0; din = '0;
        #2;
        vecs++; if (dout_orig !== 8'd0) begin errs++; $display("FAIL reset_orig got %0h exp 0", dout_orig); end
        vecs++; if (dout_dly !== 8'd0) begin errs++; $display("FAIL reset_dly got %0h exp 0", dout_dly); end
        vecs++; if (dout_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
        vecs++; if (primed !== 1'b0) begin errs++; $display("FAIL reset_primed got %b exp 0", primed); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // offset=4, din=1,2,3...: first 4 outputs masked, then din-4.
    task automatic test_fill();
        logic [7:0] e_dly;
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0, 9'd4, 8'(i));
            e_dly = (i >= 5) ? 8'(i - 4) : 8'd0;
            vecs++; if (dout_valid !== 1'b1) begin errs++; $display("FAIL fill_valid[%0d] got %b exp 1", i, dout_valid); end
            vecs++; if (dout_orig !== 8'(i)) begin errs++; $display("FAIL fill_orig[%0d] got %0d exp %0d", i, dout_orig, i); end
            vecs++; if (dout_dly !== e_dly) begin errs++; $display("FAIL fill_dly[%0d] got %0d exp %0d", i, dout_dly, e_dly); end
            vecs++; if (primed !== (i >= 5)) begin errs++; $display("FAIL fill_primed[%0d] got %b exp %b", i, primed, (i >= 5)); end
        end
    endtask

    // offset=0 uses the write-first bypass.
    task automatic test_bypass();
        do_reset();
        step(1'b1, 1'b0, 9'd0, 8'hA5);
        vecs++; if (dout_orig !== 8'hA5) begin errs++; $display("FAIL byp_orig got %0h exp a5", dout_orig); end
        vecs++; if (dout_dly !== 8'hA5) begin errs++; $display("FAIL byp_dly got %0h exp a5", dout_dly); end
        vecs++; if (primed !== 1'b1) begin errs++; $display("FAIL byp_primed got %b exp 1", primed); end
        step(1'b1, 1'b0, 9'd0, 8'h3C);
        vecs++; if (dout_dly !== 8'h3C) begin errs++; $display("FAIL byp_dly2 got %0h exp 3c", dout_dly); end
    endtask

    // 600 samples at offset=511 exercise the pointer wrap.
    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(1'b1, 1'b0, 9'd511, 8'(i));
            if (i == 510) begin
                vecs++; if (primed !== 1'b0) begin errs++; $display("FAIL wrap_primed510 got %b exp 0", primed); end
            end
            if (i == 511) begin
                vecs++; if (primed !== 1'b1) begin errs++; $display("FAIL wrap_primed511 got %b exp 1", primed); end
            end
            if (i == 512) begin
                vecs++; if (dout_dly !== 8'd1) begin errs++; $display("FAIL wrap_dly512 got %0d exp 1", dout_dly); end
            end
            if (i == 599) begin
                vecs++; if (dout_dly !== 8'd88) begin errs++; $display("FAIL wrap_dly599 got %0d exp 88", dout_dly); end
                vecs++; if (dout_orig !== 8'd87) begin errs++; $display("FAIL wrap_orig599 got %0d exp 87", dout_orig); end
            end
        end
    endtask

    // Raising offset beyond the fill count drops primed until refilled.
    task automatic test_offset_increase();
        logic [7:0] e_dly;
        do_reset();
        for (int k = 1; k <= 10; k++) step(1'b1, 1'b0, 9'd4, 8'(k));
        vecs++; if (dout_dly !== 8'd6) begin errs++; $display("FAIL inc_dly10 got %0d exp 6", dout_dly); end
        step(1'b0, 1'b0, 9'd20, 8'd0);
        vecs++; if (primed !== 1'b0) begin errs++; $display("FAIL inc_primed_drop got %b exp 0", primed); end
        vecs++; if (dout_valid !== 1'b0) begin errs++; $display("FAIL inc_valid_idle got %b exp 0", dout_valid); end
        vecs++; if (dout_dly !== 8'd6) begin errs++; $display("FAIL inc_dly_hold got %0d exp 6", dout_dly); end
        for (int k = 11; k <= 24; k++) begin
            step(1'b1, 1'b0, 9'd20, 8'(k));
            e_dly = (k >= 21) ? 8'(k - 20) : 8'd0;
            vecs++; if (primed !== (k >= 21)) begin errs++; $display("FAIL inc_primed[%0d] got %b exp %b", k, primed, (k >= 21)); end
            vecs++; if (dout_dly !== e_dly) begin errs++; $display("FAIL inc_dly[%0d] got %0d exp %0d", k, dout_dly, e_dly); end
        end
    endtask

    // en every third cycle: one valid pulse each, outputs hold in between.
    task automatic test_sparse();
        logic [7:0] e_dly;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            e_dly = (k >= 3) ? 8'(k - 2) : 8'd0;
            step(1'b1, 1'b0, 9'd2, 8'(k));
            vecs++; if (dout_valid !== 1'b1) begin errs++; $display("FAIL sparse_valid[%0d] got %b exp 1", k, dout_valid); end
            vecs++; if (dout_dly !== e_dly) begin errs++; $display("FAIL sparse_dly[%0d] got %0d exp %0d", k, dout_dly, e_dly); end
            for (int j = 0; j < 2; j++) begin
                step(1'b0, 1'b0, 9'd2, 8'hFF);
                vecs++; if (dout_valid !== 1'b0) begin errs++; $display("FAIL sparse_idle_valid[%0d.%0d] got %b exp 0", k, j, dout_valid); end
                vecs++; if (dout_orig !== 8'(k)) begin errs++; $display("FAIL sparse_hold_orig[%0d.%0d] got %0d exp %0d", k, j, dout_orig, k); end
                vecs++; if (dout_dly !== e_dly) begin errs++; $display("FAIL sparse_hold_dly[%0d.%0d] got %0d exp %0d", k, j, dout_dly, e_dly); end
                vecs++; if (primed !== (k >= 3)) begin errs++; $display("FAIL sparse_primed[%0d.%0d] got %b exp %b", k, j, primed, (k >= 3)); end
            end
        end
    endtask

    // Refill after a flush: offset 4, din = base+k.
    task automatic check_refill(input logic [7:0] base, input string tag);
        logic [7:0] e_dly;
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b0, 9'd4, base + 8'(k));
            e_dly = (k >= 5) ? base + 8'(k - 4) : 8'd0;
            vecs++; if (dout_dly !== e_dly) begin errs++; $display("FAIL %s_dly[%0d] got %0h exp %0h", tag, k, dout_dly, e_dly); end
            vecs++; if (primed !== (k >= 5)) begin errs++; $display("FAIL %s_primed[%0d] got %b exp %b", tag, k, primed, (k >= 5)); end
        end
    endtask

    // clr with en during RUN zeroes outputs at the next edge and restarts fill.
    task automatic test_clr();
        do_reset();
        for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 9'd4, 8'(k));
        vecs++; if (dout_dly !== 8'd4) begin errs++; $display("FAIL clr_pre_dly got %0d exp 4", dout_dly); end
        step(1'b1, 1'b1, 9'd4, 8'h77);
        vecs++; if (dout_orig !== 8'd0) begin errs++; $display("FAIL clr_orig got %0h exp 0", dout_orig); end
        vecs++; if (dout_dly !== 8'd0) begin errs++; $display("FAIL clr_dly got %0h exp 0", dout_dly); end
        vecs++; if (dout_valid !== 1'b0) begin errs++; $display("FAIL clr_valid got %b exp 0", dout_valid); end
        vecs++; if (primed !== 1'b0) begin errs++; $display("FAIL clr_primed got %b exp 0", primed); end
        check_refill(8'h40, "clr_refill");
    endtask

    // Asynchronous reset mid-cycle during RUN clears outputs immediately.
    task automatic test_rst_mid();
        do_reset();
        for (int k = 1; k <= 8; k++) step(1'b1, 1'b0, 9'd4, 8'(k));
        en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        vecs++; if (dout_orig !== 8'd0) begin errs++; $display("FAIL rstmid_orig got %0h exp 0", dout_orig); end
        vecs++; if (dout_dly !== 8'd0) begin errs++; $display("FAIL rstmid_dly got %0h exp 0", dout_dly); end
        vecs++; if (dout_valid !== 1'b0) begin errs++; $display("FAIL rstmid_valid got %b exp 0", dout_valid); end
        vecs++; if (primed !== 1'b0) begin errs++; $display("FAIL rstmid_primed got %b exp 0", primed); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_refill(8'h80, "rst_refill");
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; offset = '0; din = '0;
        test_reset();
        test_fill();
        test_bypass();
        test_wrap();
        test_offset_increase();
        test_sparse();
        test_clr();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
